// File: rtl/uart_rx_scheduler.sv
// Receive-side scheduler for a UART: gates the receiver through an
// OFF/ARMED/ACTIVE/HOLD sequence, buffers good bytes in a small FIFO and raises irq.
module uart_rx_scheduler #(
  parameter int N      = 8,
  parameter int DEPTH  = 4,
  parameter int THRESH = 2
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     soft_rst_i,
  input  logic                     cfg_en_i,
  input  logic                     irq_en_i,
  input  logic                     clr_status_i,
  input  logic                     rx_busy_i,
  input  logic                     rx_done_i,
  input  logic                     rx_err_i,
  input  logic [N-1:0]             rx_data_i,
  output logic                     rx_en_o,
  output logic                     rx_rst_o,
  input  logic                     rd_req_i,
  output logic [N-1:0]             rd_data_o,
  output logic                     rd_valid_o,
  output logic [$clog2(DEPTH):0]   fifo_cnt_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic                     overrun_o,
  output logic                     frame_err_o,
  output logic [3:0]               err_cnt_o,
  output logic                     irq_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(THRESH);

  localparam logic [1:0] S_OFF    = 2'd0;
  localparam logic [1:0] S_ARMED  = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  mem_q [DEPTH];
  logic [N-1:0]  rd_data_q;
  logic          rd_valid_q, rd_valid_d;
  logic          overrun_q, overrun_d;
  logic          frame_err_q, frame_err_d;
  logic [3:0]    err_cnt_q, err_cnt_d;
  logic [3:0]    err_base;
  logic          irq_q, irq_d;
  logic          rx_rst_q;

  logic full, empty, listening, push_req, push, pop, drop, err_ev;

  assign full      = (cnt_q == DEPTH_C);
  assign empty     = (cnt_q == '0);
  assign listening = (state_q == S_ARMED) || (state_q == S_ACTIVE);
  assign push_req  = listening && rx_done_i && !soft_rst_i;
  assign err_ev    = listening && rx_err_i && !soft_rst_i;
  assign pop       = rd_req_i && !empty && !soft_rst_i;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push      = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    state_d     = state_q;
    rd_valid_d  = pop;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    err_base    = clr_status_i ? 4'd0 : err_cnt_q;
    err_cnt_d   = err_base;
    irq_d       = irq_en_i && ((cnt_q >= THRESH_C) || overrun_q || frame_err_q);

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);

    case (state_q)
      S_OFF:    state_d = S_ARMED;
      S_ARMED: begin
        if (rx_busy_i) state_d = S_ACTIVE;
        else if (full) state_d = S_HOLD;
      end
      S_ACTIVE: begin
        if (rx_done_i || rx_err_i) state_d = (cnt_d < DEPTH_C) ? S_ARMED : S_HOLD;
      end
      default: begin
        if (cnt_q < DEPTH_C) state_d = S_ARMED;
      end
    endcase
    if (!cfg_en_i) state_d = S_OFF;

    // Set events win over a same-cycle clear.
    if (drop)                 overrun_d = 1'b1;
    else if (clr_status_i)    overrun_d = 1'b0;
    if (err_ev)               frame_err_d = 1'b1;
    else if (clr_status_i)    frame_err_d = 1'b0;
    if (err_ev && err_base != 4'd15) err_cnt_d = err_base + 4'd1;

    if (soft_rst_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      cnt_d       = '0;
      state_d     = S_OFF;
      rd_valid_d  = 1'b0;
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
      err_cnt_d   = 4'd0;
      irq_d       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_data_i;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= S_OFF;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= 4'd0;
      irq_q       <= 1'b0;
      rx_rst_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      rd_valid_q  <= rd_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
      irq_q       <= irq_d;
      rx_rst_q    <= soft_rst_i;
      if (pop) rd_data_q <= mem_q[rd_ptr_q];
    end
  end

  assign rx_en_o     = listening;
  assign rx_rst_o    = rx_rst_q;
  assign rd_data_o   = rd_data_q;
  assign rd_valid_o  = rd_valid_q;
  assign fifo_cnt_o  = cnt_q;
  assign empty_o     = empty;
  assign full_o      = full;
  assign overrun_o   = overrun_q;
  assign frame_err_o = frame_err_q;
  assign err_cnt_o   = err_cnt_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_uart_rx_scheduler.sv
// Directed bench for uart_rx_scheduler: a queue-based reference model is checked
// against every output on each falling edge, plus literal checks per scenario.
module tb_uart_rx_scheduler;
  localparam int N = 8;
  localparam int DEPTH = 4;
  localparam int THRESH = 2;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic soft_rst = 0, cfg_en = 0, irq_en = 0, clr_status = 0;
  logic rx_busy = 0, rx_done = 0, rx_err = 0, rd_req = 0;
  logic [N-1:0] rx_data = '0;
  logic rx_en, rx_rst, rd_valid, empty, full, overrun, frame_err, irq;
  logic [N-1:0] rd_data;
  logic [$clog2(DEPTH):0] fifo_cnt;
  logic [3:0] err_cnt;

  int tests = 0;
  int fails = 0;

  uart_rx_scheduler #(.N(N), .DEPTH(DEPTH), .THRESH(THRESH)) dut (
    .clk(clk), .arst_n(arst_n), .soft_rst_i(soft_rst), .cfg_en_i(cfg_en),
    .irq_en_i(irq_en), .clr_status_i(clr_status), .rx_busy_i(rx_busy),
    .rx_done_i(rx_done), .rx_err_i(rx_err), .rx_data_i(rx_data),
    .rx_en_o(rx_en), .rx_rst_o(rx_rst), .rd_req_i(rd_req), .rd_data_o(rd_data),
    .rd_valid_o(rd_valid), .fifo_cnt_o(fifo_cnt), .empty_o(empty), .full_o(full),
    .overrun_o(overrun), .frame_err_o(frame_err), .err_cnt_o(err_cnt), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: receiver mode, byte queue and sticky status.
  localparam int M_OFF = 0, M_LISTEN = 1, M_FRAME = 2, M_STALL = 3;
  int        m_mode = M_OFF;
  bit [7:0]  m_q[$];
  bit [7:0]  m_rd_data = 0;
  bit        m_rd_valid = 0, m_ovr = 0, m_fe = 0, m_irq = 0, m_rx_rst = 0;
  int        m_ec = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (arst_n) begin
        if (soft_rst) begin
          m_q.delete();
          m_mode = M_OFF; m_ovr = 0; m_fe = 0; m_ec = 0;
          m_rx_rst = 1; m_rd_valid = 0; m_irq = 0;
        end else begin
          int  n;
          bit  listen, ovr_set, nirq;
          n = m_q.size();
          nirq = irq_en && (n >= THRESH || m_ovr || m_fe);
          listen = (m_mode == M_LISTEN) || (m_mode == M_FRAME);
          ovr_set = 0;
          m_rd_valid = rd_req && n > 0;
          if (m_rd_valid) m_rd_data = m_q.pop_front();
          if (listen && rx_done) begin
            if (m_q.size() < DEPTH) m_q.push_back(rx_data);
            else ovr_set = 1;
          end
          if (ovr_set) m_ovr = 1; else if (clr_status) m_ovr = 0;
          if (listen && rx_err) m_fe = 1; else if (clr_status) m_fe = 0;
          if (clr_status) m_ec = 0;
          if (listen && rx_err && m_ec < 15) m_ec = m_ec + 1;
          if (!cfg_en) m_mode = M_OFF;
          else case (m_mode)
            M_OFF:    m_mode = M_LISTEN;
            M_LISTEN: if (rx_busy) m_mode = M_FRAME; else if (n == DEPTH) m_mode = M_STALL;
            M_FRAME:  if (rx_done || rx_err) m_mode = (m_q.size() < DEPTH) ? M_LISTEN : M_STALL;
            default:  if (n < DEPTH) m_mode = M_LISTEN;
          endcase
          m_rx_rst = 0;
          m_irq = nirq;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("rx_en", rx_en, (m_mode == M_LISTEN || m_mode == M_FRAME));
    chk("rx_rst", rx_rst, m_rx_rst);
    chk("rd_valid", rd_valid, m_rd_valid);
    chk("rd_data", rd_data, m_rd_data);
    chk("fifo_cnt", fifo_cnt, m_q.size());
    chk("empty", empty, m_q.size() == 0);
    chk("full", full, m_q.size() == DEPTH);
    chk("overrun", overrun, m_ovr);
    chk("frame_err", frame_err, m_fe);
    chk("err_cnt", err_cnt, m_ec);
    chk("irq", irq, m_irq);
    if (rd_valid) $display("[TB] t=%0t pop data=0x%02h cnt=%0d", $time, rd_data, fifo_cnt);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic done(input logic [7:0] d);
    rx_data = d; rx_done = 1; tick(); rx_done = 0;
  endtask

  task automatic rd();
    rd_req = 1; tick(); rd_req = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end before 200000");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_empty", empty, 1);
    chk("rst_cnt", fifo_cnt, 0);
    chk("rst_rx_en", rx_en, 0);
    arst_n = 1;
    tick();

    // In-order delivery of three bytes
    cfg_en = 1; tick();
    chk("arm_rx_en", rx_en, 1);
    done(8'h11); done(8'h22); done(8'h33);
    chk("three_cnt", fifo_cnt, 3);
    irq_en = 1; tick();
    chk("irq_thresh", irq, 1);
    irq_en = 0;
    rd(); chk("rd1_valid", rd_valid, 1); chk("rd1_data", rd_data, 8'h11);
    rd(); chk("rd2_data", rd_data, 8'h22);
    rd(); chk("rd3_data", rd_data, 8'h33);
    chk("end_empty", empty, 1);
    rd(); chk("rd_empty_ignored", rd_valid, 0);
    $display("[TB] scenario in-order done");

    // Overflow: fifth frame dropped, receiver held off until a pop
    done(8'h01); done(8'h02); done(8'h03); done(8'h04);
    rx_busy = 1; tick();
    chk("ovf_active_rx_en", rx_en, 1);
    rx_data = 8'h05; rx_done = 1; tick(); rx_done = 0; rx_busy = 0;
    chk("ovf_overrun", overrun, 1);
    chk("ovf_cnt", fifo_cnt, 4);
    chk("ovf_hold_rx_en", rx_en, 0);
    rd(); chk("ovf_rd_data", rd_data, 8'h01);
    tick(); chk("ovf_rearm_rx_en", rx_en, 1);
    $display("[TB] scenario overflow done");

    // Full FIFO with coincident pop and push
    clr_status = 1; tick(); clr_status = 0;
    chk("clr_overrun", overrun, 0);
    done(8'hAA);
    chk("full_flag", full, 1);
    rx_data = 8'h55; rx_done = 1; rd_req = 1; tick(); rx_done = 0; rd_req = 0;
    chk("coinc_cnt", fifo_cnt, 4);
    chk("coinc_overrun", overrun, 0);
    chk("coinc_rd_data", rd_data, 8'h02);
    rd(); rd(); rd();
    chk("coinc_aa", rd_data, 8'hAA);
    rd(); chk("coinc_55_last", rd_data, 8'h55);
    tick();
    $display("[TB] scenario coincident done");

    // Framing errors saturate the counter
    for (int i = 0; i < 17; i++) begin
      rx_err = 1; tick(); rx_err = 0;
      if (i == 0) chk("err_first", err_cnt, 1);
    end
    chk("err_sat", err_cnt, 15);
    chk("err_flag", frame_err, 1);
    chk("err_no_push", fifo_cnt, 0);
    irq_en = 1; tick(); chk("irq_frame_err", irq, 1); irq_en = 0;
    clr_status = 1; tick(); clr_status = 0;
    chk("err_clr_cnt", err_cnt, 0);
    chk("err_clr_flag", frame_err, 0);
    $display("[TB] scenario framing errors done");

    // Disable mid-frame
    done(8'h66); done(8'h77);
    rx_busy = 1; tick();
    cfg_en = 0; tick();
    chk("dis_rx_en", rx_en, 0);
    rx_busy = 0;
    done(8'h99);
    chk("dis_ignored_cnt", fifo_cnt, 2);
    cfg_en = 1; tick();
    rd(); chk("dis_rd1", rd_data, 8'h66);
    rd(); chk("dis_rd2", rd_data, 8'h77);
    $display("[TB] scenario disable done");

    // Soft reset flushes everything
    done(8'hC1); done(8'hC2); done(8'hC3); done(8'hC4); done(8'hC5);
    rd();
    chk("pre_soft_cnt", fifo_cnt, 3);
    chk("pre_soft_overrun", overrun, 1);
    soft_rst = 1; tick(); soft_rst = 0;
    chk("soft_cnt", fifo_cnt, 0);
    chk("soft_overrun", overrun, 0);
    chk("soft_rx_rst", rx_rst, 1);
    chk("soft_rx_en", rx_en, 0);
    tick();
    chk("soft_rx_rst_end", rx_rst, 0);
    $display("[TB] scenario soft reset done");

    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
